// File: rtl/io_bridge_pkg.sv
// io_bridge_pkg: shared state encoding and constants for the IO bus bridge
package io_bridge_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;
  localparam logic [31:0] ERR_RDATA_DEF = 32'hFFFF_FFFF;
  localparam int WD_W = 16;
endpackage

// File: rtl/io_watchdog.sv
// io_watchdog: saturating transaction watchdog with clear/enable
module io_watchdog import io_bridge_pkg::*; #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic RESET,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam logic [WD_W-1:0] LIMIT = WD_W'(TIMEOUT_CYCLES - 1);
  logic [WD_W-1:0] cnt;
  always_ff @(posedge clk or negedge RESET)
    if (!RESET) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en && cnt != '1) cnt <= cnt + WD_W'(1);
  // cnt lags the active-cycle count by one, so this fires on the edge that completes TIMEOUT_CYCLES
  assign expired = cnt >= LIMIT;
endmodule

// File: rtl/io_bridge.sv
// io_bridge: sequences one CPU IO read/write at a time onto the io_* handshake, with watchdog abort
module io_bridge import io_bridge_pkg::*; #(
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEF
) (
  input  logic        clk,
  input  logic        RESET,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_wmask,
  input  logic        cpu_rstrb,
  input  logic        cpu_wstrb,
  output logic [31:0] cpu_rdata,
  output logic        cpu_rbusy,
  output logic        cpu_wbusy,
  output logic        io_valid,
  output logic [31:0] io_addr,
  output logic [31:0] io_wdata,
  output logic [3:0]  io_wstrb,
  input  logic [31:0] io_rdata,
  input  logic        io_ready,
  output logic        timeout_flag,
  input  logic        timeout_clr
);
  state_t state, state_d;
  logic idle, wr_start, rd_start, expired, done, tmo;
  assign idle = state == ST_IDLE;
  // an empty-mask write degrades to a read; write beats read when both strobe
  always_comb begin
    wr_start = idle & cpu_wstrb & (|cpu_wmask);
    rd_start = idle & ~wr_start & (cpu_rstrb | cpu_wstrb);
    done     = ~idle & (io_ready | expired);
    tmo      = ~idle & ~io_ready & expired;
    state_d  = wr_start ? ST_WRITE : rd_start ? ST_READ : done ? ST_IDLE : state;
  end
  always_ff @(posedge clk or negedge RESET)
    if (!RESET) state <= ST_IDLE;
    else state <= state_d;
  always_ff @(posedge clk or negedge RESET)
    if (!RESET) begin
      io_addr      <= '0;
      io_wdata     <= '0;
      io_wstrb     <= '0;
      cpu_rdata    <= '0;
      timeout_flag <= 1'b0;
    end else begin
      if (wr_start | rd_start) begin
        io_addr  <= cpu_addr;
        io_wdata <= cpu_wdata;
        io_wstrb <= wr_start ? cpu_wmask : 4'd0;
      end
      if (state == ST_READ && done) cpu_rdata <= io_ready ? io_rdata : ERR_RDATA;
      if (tmo) timeout_flag <= 1'b1;
      else if (timeout_clr) timeout_flag <= 1'b0;
    end
  assign io_valid  = ~idle;
  assign cpu_rbusy = (state == ST_READ) | rd_start;
  assign cpu_wbusy = (state == ST_WRITE) | wr_start;
  io_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wd (
    .clk(clk),
    .RESET(RESET),
    .clr(idle),
    .en(~idle),
    .expired(expired)
  );
endmodule

// File: tb/tb_io_bridge.sv
// tb_io_bridge: directed and randomized checks of io_bridge against a transaction-level model
module tb_io_bridge;
  localparam int T = 8;
  localparam logic [31:0] ERR = 32'hFFFF_FFFF;
  logic clk = 1'b0, RESET = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0, io_rdata = '0;
  logic [3:0] cpu_wmask = '0;
  logic cpu_rstrb = 1'b0, cpu_wstrb = 1'b0, io_ready = 1'b0, timeout_clr = 1'b0;
  logic [31:0] cpu_rdata, io_addr, io_wdata;
  logic [3:0] io_wstrb;
  logic cpu_rbusy, cpu_wbusy, io_valid, timeout_flag;
  int n_tests = 0, n_fail = 0;
  logic [31:0] m_rdata;
  logic m_flag;

  always #5 clk = ~clk;

  io_bridge #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .RESET(RESET), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_wmask(cpu_wmask), .cpu_rstrb(cpu_rstrb), .cpu_wstrb(cpu_wstrb),
    .cpu_rdata(cpu_rdata), .cpu_rbusy(cpu_rbusy), .cpu_wbusy(cpu_wbusy),
    .io_valid(io_valid), .io_addr(io_addr), .io_wdata(io_wdata), .io_wstrb(io_wstrb),
    .io_rdata(io_rdata), .io_ready(io_ready), .timeout_flag(timeout_flag),
    .timeout_clr(timeout_clr)
  );

  // a strobe while a transaction is on the external bus is a CPU protocol violation
  always @(posedge clk)
    if (RESET && (cpu_rstrb || cpu_wstrb))
      assert (!io_valid) else begin
        n_fail++;
        $error("FAIL protocol: strobe with io_valid=%b, required 0", io_valid);
      end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // kind: 0 read strobe, 1 write strobe, 2 both strobes; d = io_valid cycles before io_ready
  task automatic run(input int kind, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] m, input int d, input logic [31:0] rv, input string tag);
    logic is_wr, tmo;
    int nv, busy, valid, wrong, wsbad;
    logic [31:0] ca, cw;
    logic [3:0] cm;
    is_wr = kind != 0 && m != 0;
    tmo = d + 1 > T;
    nv = tmo ? T : d + 1;
    busy = 0; valid = 0; wrong = 0; wsbad = 0; ca = 'x; cw = 'x; cm = 'x;
    cpu_addr = a; cpu_wdata = wd; cpu_wmask = m; io_rdata = rv;
    cpu_rstrb = kind != 1; cpu_wstrb = kind != 0;
    for (int k = 0; k < 60; k++) begin
      if (k > 0) begin
        cpu_rstrb = 1'b0; cpu_wstrb = 1'b0; io_ready = k == d + 1;
      end
      #1;
      if (!(cpu_rbusy || cpu_wbusy)) break;
      busy++;
      if (io_valid) valid++;
      if (is_wr ? cpu_rbusy : cpu_wbusy) wrong++;
      if (k == 1) begin ca = io_addr; cw = io_wdata; cm = io_wstrb; end
      if (io_valid && io_wstrb !== (is_wr ? m : 4'd0)) wsbad++;
      @(negedge clk);
    end
    io_ready = 1'b0;
    if (!is_wr) m_rdata = tmo ? ERR : rv;
    m_flag = timeout_clr ? tmo : (m_flag | tmo);
    chk({tag, ".busy"}, busy, nv + 1);
    chk({tag, ".valid"}, valid, nv);
    chk({tag, ".wrongbusy"}, wrong, 0);
    chk({tag, ".wstrb_hold"}, wsbad, 0);
    chk({tag, ".addr"}, ca, a);
    chk({tag, ".wdata"}, cw, wd);
    chk({tag, ".wstrb"}, {28'd0, cm}, {28'd0, is_wr ? m : 4'd0});
    chk({tag, ".rdata"}, cpu_rdata, m_rdata);
    chk({tag, ".flag"}, timeout_flag, m_flag);
  endtask

  task automatic clr_pulse();
    timeout_clr = 1'b1;
    @(negedge clk);
    timeout_clr = 1'b0;
    #1;
    m_flag = 1'b0;
    chk("clr.flag", timeout_flag, 0);
  endtask

  initial begin
    int kind, d;
    logic [3:0] m;
    m_rdata = '0; m_flag = 1'b0;
    #12;
    chk("rst.rdata", cpu_rdata, 0);
    chk("rst.busy", {cpu_rbusy, cpu_wbusy, io_valid}, 0);
    chk("rst.addr", io_addr, 0);
    chk("rst.wdata", io_wdata, 0);
    chk("rst.wstrb", io_wstrb, 0);
    chk("rst.flag", timeout_flag, 0);
    @(negedge clk); RESET = 1'b1;
    @(negedge clk);
    run(0, 32'h0040_0100, 32'h0, 4'h0, 2, 32'h0000_0155, "rd3");
    run(1, 32'h0040_0008, 32'hA5, 4'b0001, 0, 32'h1234_5678, "wr0");
    run(0, 32'h0040_0010, 32'h0, 4'h0, 20, 32'h5555_5555, "rdtmo");
    clr_pulse();
    run(2, 32'h0040_0020, 32'hCAFE_F00D, 4'hF, 1, 32'h7777_7777, "both");
    run(0, 32'h0040_0024, 32'h0, 4'h0, T - 1, 32'hBEEF_0001, "edge");
    timeout_clr = 1'b1;
    run(1, 32'h0040_0028, 32'h11, 4'b0110, 30, 32'h0, "setwin");
    timeout_clr = 1'b0;
    clr_pulse();
    run(1, 32'h0040_002C, 32'h22, 4'b0000, 3, 32'h0BAD_C0DE, "mask0");
    cpu_addr = 32'h0040_0030; cpu_wdata = 32'h33; cpu_wmask = 4'hF; cpu_wstrb = 1'b1;
    @(negedge clk);
    cpu_wstrb = 1'b0;
    #1;
    chk("rstmid.pre", {io_valid, cpu_wbusy}, 2'b11);
    #2 RESET = 1'b0;
    #1;
    m_rdata = '0; m_flag = 1'b0;
    chk("rstmid.busy", {io_valid, cpu_wbusy}, 0);
    chk("rstmid.wstrb", io_wstrb, 0);
    chk("rstmid.rdata", cpu_rdata, 0);
    @(negedge clk); RESET = 1'b1;
    @(negedge clk);
    run(0, 32'h0040_0034, 32'h0, 4'h0, 1, 32'h0000_0ACE, "postrst");
    run(1, 32'h0040_0038, 32'h44, 4'b1000, 2, 32'h0, "b2b_wr");
    run(0, 32'h0040_003C, 32'h0, 4'h0, 0, 32'h9999_0000, "b2b_rd");
    for (int i = 0; i < 20; i++) begin
      kind = $urandom_range(0, 3);
      d = $urandom_range(0, 10);
      m = kind == 3 ? 4'd0 : 4'($urandom_range(1, 15));
      run(kind == 3 ? 1 : kind, $urandom, $urandom, m, d, $urandom, $sformatf("rnd%0d", i));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
